// File: rtl/mem_store_buffer.sv
// Posted-write store buffer between the EX/MEM stage and a slow data ram.
// Stores retire into a FIFO in one cycle; loads forward youngest-first or read ram on a miss.
module mem_store_buffer #(
  parameter int DEPTH        = 4,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        empty,
  output logic        ram_read_enable,
  output logic        ram_write_enable,
  output logic [31:0] ram_address,
  output logic [31:0] ram_data_in,
  input  logic [31:0] ram_data_out
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [CNT_W-1:0]   FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  typedef logic [PTR_W-1:0] ptr_t;

  typedef enum logic {
    S_IDLE,
    S_DRAIN
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

  entry_t             entries [DEPTH];
  ptr_t               head_q;
  ptr_t               tail_q;
  logic [CNT_W-1:0]   count_q;
  state_t             state_q;
  state_t             state_d;
  logic [DRAIN_W-1:0] cnt_q;
  logic [DRAIN_W-1:0] cnt_d;

  entry_t      head_entry;
  ptr_t        scan_idx;
  logic        has_entries;
  logic        full;
  logic        hit;
  logic [31:0] hit_data;
  logic        load_miss;
  logic        push;
  logic        pop;

  assign head_entry  = entries[head_q];
  assign has_entries = (count_q != '0);
  assign full        = (count_q == FULL_COUNT);

  // Walk oldest to youngest so the last match (the youngest store) wins.
  // NOTE: every signal driven in an always_comb gets a default at the top; a missing branch would otherwise infer a latch.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    scan_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + ptr_t'(i);
      if ((CNT_W'(i) < count_q) && (entries[scan_idx].addr == address)) begin
        hit      = 1'b1;
        hit_data = entries[scan_idx].data;
      end
    end
  end

  assign load_miss = mem_read & ~hit;
  // A simultaneous load takes precedence; the store half of such a request is dropped.
  assign push      = mem_write & ~mem_read & ~full;

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    pop              = 1'b0;
    ready            = 1'b1;
    read_data        = '0;
    ram_read_enable  = 1'b0;
    ram_write_enable = 1'b0;
    ram_address      = head_entry.addr;
    ram_data_in      = head_entry.data;

    case (state_q)
      S_IDLE: begin
        if (load_miss) begin
          ram_read_enable = 1'b1;
          ram_address     = address;
          read_data       = ram_data_out;
        end else if (has_entries) begin
          state_d = S_DRAIN;
          cnt_d   = DRAIN_LAST;
        end
      end
      S_DRAIN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DRAIN_W'(1);
        end else begin
          ram_write_enable = 1'b1;
          pop              = 1'b1;
          state_d          = S_IDLE;
        end
        // The ram port is busy; a missing load waits for the drain to finish.
        if (load_miss) ready = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    if (mem_read && hit) begin
      read_data = hit_data;
    end else if (mem_write && !mem_read && full) begin
      ready = 1'b0;
    end

    // Reset cuts off the port immediately so an in-flight drain never reaches ram.
    if (reset) begin
      pop              = 1'b0;
      ready            = 1'b1;
      read_data        = '0;
      ram_read_enable  = 1'b0;
      ram_write_enable = 1'b0;
    end
  end

  assign empty = reset | ~has_entries;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (push) tail_q <= tail_q + ptr_t'(1);
      if (pop)  head_q <= head_q + ptr_t'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: the entry array is deliberately not reset; count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push && !reset) entries[tail_q] <= '{addr: address, data: write_data};
  end

endmodule

// File: tb/tb_mem_store_buffer.sv
// Self-checking bench for mem_store_buffer: directed scenarios plus randomized
// traffic against a queue-based model of the buffer and its backing ram.
module tb_mem_store_buffer;

  localparam int DEPTH        = 4;
  localparam int DRAIN_CYCLES = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic        empty;
  logic        ram_read_enable;
  logic        ram_write_enable;
  logic [31:0] ram_address;
  logic [31:0] ram_data_in;
  logic [31:0] ram_data_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_store_buffer #(.DEPTH(DEPTH), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
    .clk              (clk),
    .reset            (reset),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .address          (address),
    .write_data       (write_data),
    .read_data        (read_data),
    .ready            (ready),
    .empty            (empty),
    .ram_read_enable  (ram_read_enable),
    .ram_write_enable (ram_write_enable),
    .ram_address      (ram_address),
    .ram_data_in      (ram_data_in),
    .ram_data_out     (ram_data_out)
  );

  // Backing ram: 64 words decoded from address bits [7:2], combinational read.
  logic [31:0] ram_mem [64];
  assign ram_data_out = ram_mem[ram_address[7:2]];
  always @(posedge clk) if (ram_write_enable) ram_mem[ram_address[7:2]] <= ram_data_in;

  // Reference model: pending stores in age order, drain progress, and the ram contents they produce.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } st_t;

  st_t         mq[$];
  int          phase = 0;
  logic [31:0] ref_ram [64];

  logic        exp_ready, exp_empty, exp_re, exp_we, exp_miss;
  logic [31:0] exp_rd, exp_wa, exp_wd;

  function automatic void model_eval();
    logic        h;
    logic [31:0] hd;
    h  = 1'b0;
    hd = '0;
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].addr == address) begin
        h  = 1'b1;
        hd = mq[i].data;
      end
    exp_miss  = mem_read && !h;
    exp_we    = !reset && (phase == DRAIN_CYCLES);
    exp_re    = !reset && exp_miss && (phase == 0);
    exp_empty = reset || (mq.size() == 0);
    if (reset)          exp_ready = 1'b1;
    else if (mem_read)  exp_ready = h || (phase == 0);
    else if (mem_write) exp_ready = (mq.size() < DEPTH);
    else                exp_ready = 1'b1;
    if (reset || !mem_read) exp_rd = '0;
    else if (h)             exp_rd = hd;
    else if (phase == 0)    exp_rd = ref_ram[address[7:2]];
    else                    exp_rd = '0;
    exp_wa = '0;
    exp_wd = '0;
    if (exp_we) begin
      exp_wa = mq[0].addr;
      exp_wd = mq[0].data;
    end
  endfunction

  function automatic void model_update();
    int  sz;
    st_t head;
    logic accept;
    if (reset) begin
      mq.delete();
      phase = 0;
      return;
    end
    sz     = mq.size();
    accept = mem_write && !mem_read && (sz < DEPTH);
    if (phase == DRAIN_CYCLES) begin
      head = mq.pop_front();
      ref_ram[head.addr[7:2]] = head.data;
      phase = 0;
    end else if (phase != 0) begin
      phase++;
    end else if (sz > 0 && !exp_miss) begin
      phase = 1;
    end
    if (accept) mq.push_back('{addr: address, data: write_data});
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic drive(input logic rst, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] d);
    reset      = rst;
    mem_read   = rd;
    mem_write  = wr;
    address    = a;
    write_data = d;
    model_eval();
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    advance();
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    n_vec++;
    if ({ready, empty, ram_read_enable, ram_write_enable, read_data} !== {4'b1100, 32'h0}) begin
      n_err++;
      $display("FAIL reset_active: got rdy/emp/re/we=%b rd=%h want 1100 rd=0",
               {ready, empty, ram_read_enable, ram_write_enable}, read_data);
    end
    advance();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      n_vec++;
      if ({ready, empty, ram_read_enable, ram_write_enable, read_data} !== {4'b1100, 32'h0}) begin
        n_err++;
        $display("FAIL reset_idle c%0d: got rdy/emp/re/we=%b rd=%h want 1100 rd=0",
                 c, {ready, empty, ram_read_enable, ram_write_enable}, read_data);
      end
      advance();
    end
  endtask

  task automatic test_single_drain();
    logic want_we, want_empty;
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 32'h10, 32'hAA);
    n_vec++;
    if (ready !== 1'b1) begin
      n_err++;
      $display("FAIL single_store_ready: got %b want 1", ready);
    end
    advance();
    for (int c = 1; c <= 4; c++) begin
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      want_we    = (c == 3);
      want_empty = (c == 4);
      n_vec++;
      if ({ram_write_enable, empty} !== {want_we, want_empty}) begin
        n_err++;
        $display("FAIL single_drain c%0d: got we/empty=%b%b want %b%b",
                 c, ram_write_enable, empty, want_we, want_empty);
      end
      if (c == 3) begin
        n_vec++;
        if ({ram_address, ram_data_in} !== {32'h10, 32'hAA}) begin
          n_err++;
          $display("FAIL single_drain_port: got %h/%h want 00000010/000000aa", ram_address, ram_data_in);
        end
      end
      advance();
    end
  endtask

  task automatic test_full_stall();
    int          k;
    logic        want_ready, want_we;
    logic [31:0] want_addr, want_data;
    k = 0;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, 1'b0, 1'b1, 32'h100 + 32'(4 * k), 32'hC0 + 32'(k));
      want_ready = !(c == 5 || c == 6);
      want_we    = (c == 3 || c == 6);
      want_addr  = (c == 3) ? 32'h100 : 32'h104;
      want_data  = (c == 3) ? 32'hC0 : 32'hC1;
      n_vec++;
      if ({ready, ram_write_enable} !== {want_ready, want_we}) begin
        n_err++;
        $display("FAIL full_stall c%0d: got ready/we=%b%b want %b%b",
                 c, ready, ram_write_enable, want_ready, want_we);
      end
      if (want_we) begin
        n_vec++;
        if ({ram_address, ram_data_in} !== {want_addr, want_data}) begin
          n_err++;
          $display("FAIL full_stall_port c%0d: got %h/%h want %h/%h",
                   c, ram_address, ram_data_in, want_addr, want_data);
        end
      end
      if (want_ready) k++;
      advance();
    end
  endtask

  task automatic test_forwarding();
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 32'h20, 32'h1);
    advance();
    drive(1'b0, 1'b0, 1'b1, 32'h20, 32'h2);
    advance();
    drive(1'b0, 1'b1, 1'b0, 32'h20, '0);
    n_vec++;
    if ({ready, ram_read_enable, read_data} !== {2'b10, 32'h2}) begin
      n_err++;
      $display("FAIL fwd_youngest: got ready/re=%b%b rd=%h want 10 rd=2", ready, ram_read_enable, read_data);
    end
    advance();
    // Differs only in bit 31: must not forward, and the drain owns the port this cycle.
    drive(1'b0, 1'b1, 1'b0, 32'h8000_0020, '0);
    n_vec++;
    if ({ready, ram_read_enable, ram_write_enable, read_data} !== {3'b001, 32'h0}) begin
      n_err++;
      $display("FAIL fwd_alias_stall: got ready/re/we=%b%b%b rd=%h want 001 rd=0",
               ready, ram_read_enable, ram_write_enable, read_data);
    end
    n_vec++;
    if ({ram_address, ram_data_in} !== {32'h20, 32'h1}) begin
      n_err++;
      $display("FAIL fwd_oldest_drained: got %h/%h want 00000020/00000001", ram_address, ram_data_in);
    end
    advance();
    // The ram decodes word bits only, so this read sees the value drained last cycle.
    drive(1'b0, 1'b1, 1'b0, 32'h8000_0020, '0);
    n_vec++;
    if ({ready, ram_read_enable, ram_address, read_data} !== {2'b11, 32'h8000_0020, 32'h1}) begin
      n_err++;
      $display("FAIL fwd_alias_miss: got ready/re=%b%b addr=%h rd=%h want 11 addr=80000020 rd=1",
               ready, ram_read_enable, ram_address, read_data);
    end
    advance();
  endtask

  task automatic test_load_miss_drain();
    logic want_we;
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 32'h10, 32'h55);
    advance();
    drive(1'b0, 1'b0, 1'b1, 32'h14, 32'h66);
    advance();
    for (int c = 2; c <= 3; c++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h40, '0);
      want_we = (c == 3);
      n_vec++;
      if ({ready, ram_read_enable, ram_write_enable} !== {2'b00, want_we}) begin
        n_err++;
        $display("FAIL miss_in_drain c%0d: got ready/re/we=%b%b%b want 00%b",
                 c, ready, ram_read_enable, ram_write_enable, want_we);
      end
      advance();
    end
    drive(1'b0, 1'b1, 1'b0, 32'h40, '0);
    n_vec++;
    if ({ready, ram_read_enable, ram_write_enable, ram_address, read_data} !==
        {3'b110, 32'h40, 32'hD000_0010}) begin
      n_err++;
      $display("FAIL miss_served: got ready/re/we=%b%b%b addr=%h rd=%h want 110 addr=40 rd=d0000010",
               ready, ram_read_enable, ram_write_enable, ram_address, read_data);
    end
    advance();
    for (int c = 5; c <= 7; c++) begin
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      want_we = (c == 7);
      n_vec++;
      if (ram_write_enable !== want_we) begin
        n_err++;
        $display("FAIL drain_deferred c%0d: got we=%b want %b", c, ram_write_enable, want_we);
      end
      if (want_we) begin
        n_vec++;
        if ({ram_address, ram_data_in} !== {32'h14, 32'h66}) begin
          n_err++;
          $display("FAIL drain_deferred_port: got %h/%h want 00000014/00000066", ram_address, ram_data_in);
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b0, 1'b1, 32'h30 + 32'(4 * c), 32'h300 + 32'(c));
      advance();
    end
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    n_vec++;
    if ({ready, empty, ram_write_enable} !== 3'b110) begin
      n_err++;
      $display("FAIL reset_abort: got ready/empty/we=%b%b%b want 110", ready, empty, ram_write_enable);
    end
    advance();
    for (int c = 4; c <= 6; c++) begin
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      n_vec++;
      if ({ready, empty, ram_write_enable} !== 3'b110) begin
        n_err++;
        $display("FAIL reset_after c%0d: got ready/empty/we=%b%b%b want 110",
                 c, ready, empty, ram_write_enable);
      end
      advance();
    end
    n_vec++;
    if (ram_mem[12] !== 32'hD000_000C) begin
      n_err++;
      $display("FAIL reset_no_write: ram[0x30] got %h want d000000c", ram_mem[12]);
    end
  endtask

  task automatic test_random();
    logic        rd, wr, rst, hold;
    logic [31:0] a, d;
    int          r;
    rd = 1'b0; wr = 1'b0; a = '0; d = '0; hold = 1'b0;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (!hold) begin
        r  = $urandom_range(0, 99);
        rd = (r < 35) || (r >= 95);
        wr = (r >= 35 && r < 75) || (r >= 95);
        a  = 32'($urandom_range(0, 7)) << 2;
        if ($urandom_range(0, 7) == 0) a[31] = 1'b1;
        d  = $urandom;
      end
      rst = ($urandom_range(0, 199) == 0);
      drive(rst, rd, wr, a, d);
      n_vec++;
      if ({ready, empty, ram_read_enable, ram_write_enable} !== {exp_ready, exp_empty, exp_re, exp_we}) begin
        n_err++;
        $display("FAIL rand_ctrl n%0d: got rdy/emp/re/we=%b want %b", n,
                 {ready, empty, ram_read_enable, ram_write_enable}, {exp_ready, exp_empty, exp_re, exp_we});
      end
      n_vec++;
      if (read_data !== exp_rd) begin
        n_err++;
        $display("FAIL rand_read_data n%0d: got %h want %h", n, read_data, exp_rd);
      end
      if (exp_re) begin
        n_vec++;
        if (ram_address !== address) begin
          n_err++;
          $display("FAIL rand_read_addr n%0d: got %h want %h", n, ram_address, address);
        end
      end
      if (exp_we) begin
        n_vec++;
        if ({ram_address, ram_data_in} !== {exp_wa, exp_wd}) begin
          n_err++;
          $display("FAIL rand_write_port n%0d: got %h/%h want %h/%h", n, ram_address, ram_data_in, exp_wa, exp_wd);
        end
      end
      hold = !rst && !exp_ready;
      advance();
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      ram_mem[i] = 32'hD000_0000 + 32'(i);
      ref_ram[i] = 32'hD000_0000 + 32'(i);
    end
    reset      = 1'b1;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    address    = '0;
    write_data = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_drain();
    test_full_stall();
    test_forwarding();
    test_load_miss_drain();
    test_reset_in_drain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
